// File: rtl/wb_align_stage.sv
// Writeback alignment stage: formats ALU/LOAD/LINK results into one registered RF write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_align_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  input  logic [1:0]            ld_off,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [WIDTH-1:0]      z_in,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  halted,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]           retire_cnt,
`endif
  output logic                  misalign
);

  localparam logic [2:0] OpAlu  = 3'd1;
  localparam logic [2:0] OpLoad = 3'd2;
  localparam logic [2:0] OpLink = 3'd3;
  localparam logic [2:0] OpHalt = 3'd4;

  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzByte = 2'd2;

  localparam logic [REG_ADDR_W-1:0] LinkAddr = REG_ADDR_W'(LINK_REG);

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                  halted_q, halted_d;
  logic                  misalign_q, misalign_d;

  logic                  accept;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [WIDTH-1:0]      load_data;

  assign accept = in_valid && !halted_q;

  always_comb begin
    byte_lane = 8'h00;
    unique case (ld_off)
      2'd0: byte_lane = z_in[7:0];
      2'd1: byte_lane = z_in[15:8];
      2'd2: byte_lane = z_in[23:16];
      2'd3: byte_lane = z_in[31:24];
      default: byte_lane = z_in[7:0];
    endcase
    half_lane = ld_off[1] ? z_in[31:16] : z_in[15:0];
  end

  always_comb begin
    load_data = z_in;
    if (ld_size == SzByte) begin
      load_data = {{(WIDTH-8){ld_signed & byte_lane[7]}}, byte_lane};
    end else if (ld_size == SzHalf) begin
      load_data = {{(WIDTH-16){ld_signed & half_lane[15]}}, half_lane};
    end
  end

  // Address/data hold unless a write-class request is accepted.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    halted_d   = halted_q;
    misalign_d = 1'b0;
    if (accept) begin
      case (op)
        OpAlu: begin
          wr_addr_d = rd;
          wr_data_d = z_in;
          wr_en_d   = (rd != '0);
        end
        OpLoad: begin
          if (ld_size == SzHalf && ld_off[0]) begin
            misalign_d = 1'b1;
          end else begin
            wr_addr_d = rd;
            wr_data_d = load_data;
            wr_en_d   = (rd != '0);
          end
        end
        OpLink: begin
          wr_addr_d = LinkAddr;
          wr_data_d = z_in;
          wr_en_d   = (LinkAddr != '0);
        end
        OpHalt: halted_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  // Counts alongside the write it retires, so the value is current in the output cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if (wr_en_d) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign in_ready = !halted_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign halted   = halted_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_wb_align_stage.sv
// Directed self-checking bench for wb_align_stage (default 32-bit configuration).
module tb_wb_align_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [1:0]  ld_off;
  logic [4:0]  rd;
  logic [31:0] z_in;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        halted;
  logic        misalign;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_align_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ld_size   (ld_size),
    .ld_signed (ld_signed),
    .ld_off    (ld_off),
    .rd        (rd),
    .z_in      (z_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .halted    (halted),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .misalign  (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request, let it be captured, and sample #1 after the edge.
  task automatic send(input logic v, input logic [2:0] o, input logic [1:0] sz, input logic sg,
                      input logic [1:0] off, input logic [4:0] r, input logic [31:0] z);
    in_valid  = v;
    op        = o;
    ld_size   = sz;
    ld_signed = sg;
    ld_off    = off;
    rd        = r;
    z_in      = z;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'd0; ld_size = 2'd0; ld_signed = 1'b0;
    ld_off = 2'd0; rd = 5'd0; z_in = 32'h0;
    #2;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rdy_after_rst", {31'd0, in_ready}, 32'd1);

    // ALU write
    send(1'b1, 3'd1, 2'd0, 1'b0, 2'd0, 5'd5, 32'h12345678);
    chk("alu_en", {31'd0, wr_en}, 32'd1);
    chk("alu_addr", {27'd0, wr_addr}, 32'd5);
    chk("alu_data", wr_data, 32'h12345678);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_one", retire_cnt, 32'd1);
`endif

    // Idle cycle: single-cycle wr_en, data holds
    send(1'b0, 3'd1, 2'd0, 1'b0, 2'd0, 5'd9, 32'hAAAA5555);
    chk("idle_en", {31'd0, wr_en}, 32'd0);
    chk("idle_addr_hold", {27'd0, wr_addr}, 32'd5);
    chk("idle_data_hold", wr_data, 32'h12345678);

    // Byte loads
    send(1'b1, 3'd2, 2'd2, 1'b1, 2'd2, 5'd7, 32'h00800000);
    chk("lb_s_en", {31'd0, wr_en}, 32'd1);
    chk("lb_s_addr", {27'd0, wr_addr}, 32'd7);
    chk("lb_s_data", wr_data, 32'hFFFFFF80);
    send(1'b1, 3'd2, 2'd2, 1'b0, 2'd2, 5'd7, 32'h00800000);
    chk("lb_u_data", wr_data, 32'h00000080);
    send(1'b1, 3'd2, 2'd2, 1'b1, 2'd0, 5'd8, 32'h123456FF);
    chk("lb_s_off0", wr_data, 32'hFFFFFFFF);
    send(1'b1, 3'd2, 2'd2, 1'b0, 2'd3, 5'd8, 32'hA5000000);
    chk("lb_u_off3", wr_data, 32'h000000A5);
    send(1'b1, 3'd2, 2'd2, 1'b1, 2'd1, 5'd8, 32'h00007F00);
    chk("lb_s_off1_pos", wr_data, 32'h0000007F);

    // Misaligned halfword
    send(1'b1, 3'd2, 2'd1, 1'b0, 2'd1, 5'd10, 32'hBEEF0000);
    chk("lh_mis_en", {31'd0, wr_en}, 32'd0);
    chk("lh_mis_pulse", {31'd0, misalign}, 32'd1);
    chk("lh_mis_data_hold", wr_data, 32'h0000007F);
    send(1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 5'd0, 32'h0);
    chk("lh_mis_one_cycle", {31'd0, misalign}, 32'd0);

    // Aligned halfwords
    send(1'b1, 3'd2, 2'd1, 1'b0, 2'd2, 5'd11, 32'hBEEF0000);
    chk("lh_u_en", {31'd0, wr_en}, 32'd1);
    chk("lh_u_data", wr_data, 32'h0000BEEF);
    send(1'b1, 3'd2, 2'd1, 1'b1, 2'd2, 5'd11, 32'hBEEF0000);
    chk("lh_s_data", wr_data, 32'hFFFFBEEF);
    send(1'b1, 3'd2, 2'd1, 1'b1, 2'd0, 5'd11, 32'hFFFF1234);
    chk("lh_s_low_pos", wr_data, 32'h00001234);

    // Word load (size 3 treated as word, offset ignored)
    send(1'b1, 3'd2, 2'd3, 1'b1, 2'd1, 5'd12, 32'hDEADBEEF);
    chk("lw_sz3_data", wr_data, 32'hDEADBEEF);
    chk("lw_sz3_addr", {27'd0, wr_addr}, 32'd12);

    // Link
    send(1'b1, 3'd3, 2'd0, 1'b0, 2'd0, 5'd3, 32'h00000040);
    chk("link_en", {31'd0, wr_en}, 32'd1);
    chk("link_addr", {27'd0, wr_addr}, 32'd31);
    chk("link_data", wr_data, 32'h00000040);

    // Write to r0 suppressed
    send(1'b1, 3'd1, 2'd0, 1'b0, 2'd0, 5'd0, 32'h11111111);
    chk("alu_r0_en", {31'd0, wr_en}, 32'd0);

    // Reserved opcode behaves as NONE
    send(1'b1, 3'd6, 2'd0, 1'b0, 2'd0, 5'd4, 32'h22222222);
    chk("op6_en", {31'd0, wr_en}, 32'd0);
    chk("op6_misalign", {31'd0, misalign}, 32'd0);

    // Asynchronous reset mid-run discards the in-flight request
    send(1'b1, 3'd1, 2'd0, 1'b0, 2'd0, 5'd4, 32'hCAFEF00D);
    chk("pre_rst_en", {31'd0, wr_en}, 32'd1);
    in_valid = 1'b1; op = 3'd1; rd = 5'd6; z_in = 32'h66666666;
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_en", {31'd0, wr_en}, 32'd0);
    chk("async_rst_data", wr_data, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("async_rst_cnt", retire_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_discard_en", {31'd0, wr_en}, 32'd0);
    chk("rst_discard_addr", {27'd0, wr_addr}, 32'd0);

    // Halt then ignored ALU
    send(1'b1, 3'd4, 2'd0, 1'b0, 2'd0, 5'd5, 32'h0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_ready", {31'd0, in_ready}, 32'd0);
    chk("halt_en", {31'd0, wr_en}, 32'd0);
    send(1'b1, 3'd1, 2'd0, 1'b0, 2'd0, 5'd5, 32'h12345678);
    chk("halted_alu_en", {31'd0, wr_en}, 32'd0);
    send(1'b1, 3'd2, 2'd1, 1'b0, 2'd1, 5'd5, 32'h12345678);
    chk("halted_mis", {31'd0, misalign}, 32'd0);
    chk("halted_en2", {31'd0, wr_en}, 32'd0);
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halted_data", wr_data, 32'd0);

    reset = 1'b1;
    #1;
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    chk("unhalt_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    send(1'b1, 3'd1, 2'd0, 1'b0, 2'd0, 5'd2, 32'h0BADF00D);
    chk("post_halt_en", {31'd0, wr_en}, 32'd1);
    chk("post_halt_data", wr_data, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_align_stage.md
WB_ALIGN_STAGE -- requirements
Module: wb_align_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width in bits (multiple of 16, at least 32).
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter LINK_REG, default 31, destination register for link writes.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream writeback request valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a request.
REQ-008 SHALL have port op  input  3  class: 0 NONE, 1 ALU, 2 LOAD, 3 LINK, 4 HALT; 5-7 treated as NONE.
REQ-009 SHALL have port ld_size  input  2  load size: 0 word, 1 halfword, 2 byte, 3 treated as word.
REQ-010 SHALL have port ld_signed  input  1  1 sign-extends sub-word loads, 0 zero-extends.
REQ-011 SHALL have port ld_off  input  2  byte offset of the load within the low 32 bits of z_in.
REQ-012 SHALL have port rd  input  REG_ADDR_W  destination register.
REQ-013 SHALL have port z_in  input  WIDTH  ALU result, load word or link address.
REQ-014 SHALL have ports wr_en (1), wr_addr (REG_ADDR_W) and wr_data (WIDTH), all outputs, forming the register-file write port.
REQ-015 SHALL have port halted  output  1  sticky halt indication.
REQ-016 SHALL have port misalign  output  1  one-cycle pulse: rejected misaligned halfword load.

Function
REQ-017 Request SHALL be accepted on a rising edge when in_valid=1 and in_ready=1; in_ready SHALL equal !halted.
REQ-018 Accepted request SHALL appear on wr_en/wr_addr/wr_data exactly one cycle after acceptance (registered outputs, latency 1).
REQ-019 wr_en SHALL be 1 for exactly one cycle per accepted ALU, LOAD or LINK request whose target is non-zero; otherwise 0.
REQ-020 Writes targeting register 0 SHALL be suppressed (wr_en=0), including LINK when LINK_REG=0.
REQ-021 ALU: wr_addr=rd, wr_data=z_in unchanged.
REQ-022 LINK: wr_addr=LINK_REG, wr_data=z_in; rd ignored.
REQ-023 LOAD word: wr_data=z_in unchanged; ld_off ignored.
REQ-024 LOAD halfword: lane = z_in bits [16*ld_off[1] +: 16], extended to WIDTH per ld_signed.
REQ-025 LOAD halfword with ld_off[0]=1: wr_en=0, misalign=1 for that one output cycle, no register updated.
REQ-026 LOAD byte: lane = z_in bits [8*ld_off +: 8], extended to WIDTH per ld_signed.
REQ-027 HALT: no write; halted SHALL rise in the output cycle and hold until reset; in_ready falls simultaneously.
REQ-028 While halted, in_valid SHALL be ignored and wr_en, misalign SHALL stay 0.
REQ-029 NONE or unaccepted cycles SHALL produce wr_en=0, misalign=0; wr_addr/wr_data hold previous values.

Reset
REQ-030 reset=1 SHALL immediately clear wr_en, wr_addr, wr_data, halted, misalign to 0 and any optional counter to 0, regardless of clock.
REQ-031 A request accepted in the same cycle reset asserts SHALL be discarded; no write is issued after reset deasserts.
REQ-032 After reset deasserts, in_ready=1 and the first rising edge may accept a request.

Configuration
REQ-033 Macro WB_RETIRE_CNT_EN defined: output retire_cnt (32 bits) SHALL increment by 1 in each output cycle with wr_en=1, wrapping 0xFFFFFFFF to 0.
REQ-034 Macro WB_RETIRE_CNT_EN undefined: retire_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-035 ALU, rd=5, z_in=0x12345678 -> next cycle wr_en=1, wr_addr=5, wr_data=0x12345678.
REQ-036 LOAD byte signed, ld_off=2, z_in=0x00800000, rd=7 -> wr_data=0xFFFFFF80; same with ld_signed=0 -> 0x00000080.
REQ-037 LOAD halfword, ld_off=1 -> wr_en=0, misalign pulses 1 for one cycle; ld_off=2, z_in=0xBEEF0000, unsigned -> wr_data=0x0000BEEF.
REQ-038 LINK, rd=3, z_in=0x40 -> wr_addr=31, wr_data=0x40; ALU, rd=0 -> wr_en=0.
REQ-039 HALT then ALU with in_valid=1 -> halted=1, in_ready=0, ALU never written; reset -> halted=0, in_ready=1.
REQ-040 With WB_RETIRE_CNT_EN, retire_cnt preloaded near 0xFFFFFFFF plus two writes -> counts 0xFFFFFFFF then 0; reset mid-run -> 0.
